// File: rtl/status_vitais.sv
// Vital-status tracker for the virtual pet: satiety, energy and lesson count
// advance once per game tick according to the current activity state.
module status_vitais #(
    parameter int TICK_DIV = 50000000,
    parameter int LIMIAR   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] estado,
    output logic [3:0] saciedade,
    output logic [3:0] energia,
    output logic [7:0] aulas,
    output logic       alerta_fome,
    output logic       alerta_sono,
    output logic       morreu
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
    localparam logic [31:0] LIM_W = LIMIAR;

    typedef enum logic [2:0] {
        OP_IDLE,
        OP_DORMINDO,
        OP_COMENDO,
        OP_AULA,
        OP_MORTO
    } op_t;

    // Saturating add: computed in 5 bits so an overflow clamps to 15 instead of wrapping.
    function automatic logic [3:0] sat_inc(input logic [3:0] lvl, input logic [1:0] amt);
        logic [4:0] sum_v;
        sum_v = {1'b0, lvl} + {3'b000, amt};
        if (sum_v > 5'd15) begin
            sat_inc = 4'd15;
        end else begin
            sat_inc = sum_v[3:0];
        end
    endfunction

    // Saturating subtract: the borrow bit flags an underflow, which clamps to 0.
    function automatic logic [3:0] sat_dec(input logic [3:0] lvl, input logic [1:0] amt);
        logic [4:0] diff_v;
        diff_v = {1'b0, lvl} - {3'b000, amt};
        if (diff_v[4]) begin
            sat_dec = 4'd0;
        end else begin
            sat_dec = diff_v[3:0];
        end
    endfunction

    logic [CNT_W-1:0] cnt_r;
    logic [3:0]       saciedade_r;
    logic [3:0]       energia_r;
    logic [7:0]       aulas_r;
    logic             morreu_r;

    logic             tick_s;
    logic             upd_s;
    logic             die_s;
    op_t              op_s;
    logic [3:0]       sac_nxt_s;
    logic [3:0]       ene_nxt_s;
    logic [7:0]       aul_nxt_s;

    assign tick_s = (cnt_r == CNT_MAX);
    assign upd_s  = tick_s & ~morreu_r;

    // Prescaler: free-running regardless of death or activity state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (tick_s) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Activity decode; unknown codes behave like IDLE.
    always_comb begin
        op_s = OP_IDLE;
        case (estado)
            4'b0000: op_s = OP_IDLE;
            4'b0001: op_s = OP_DORMINDO;
            4'b0010: op_s = OP_COMENDO;
            4'b0100: op_s = OP_AULA;
            4'b1000: op_s = OP_MORTO;
            default: op_s = OP_IDLE;
        endcase
    end

    // Candidate next levels for the current activity.
    always_comb begin
        sac_nxt_s = saciedade_r;
        ene_nxt_s = energia_r;
        aul_nxt_s = aulas_r;
        case (op_s)
            OP_IDLE: begin
                sac_nxt_s = sat_dec(saciedade_r, 2'd1);
                ene_nxt_s = sat_dec(energia_r, 2'd1);
            end
            OP_DORMINDO: begin
                sac_nxt_s = sat_dec(saciedade_r, 2'd1);
                ene_nxt_s = sat_inc(energia_r, 2'd2);
            end
            OP_COMENDO: begin
                sac_nxt_s = sat_inc(saciedade_r, 2'd2);
                ene_nxt_s = sat_dec(energia_r, 2'd1);
            end
            OP_AULA: begin
                sac_nxt_s = sat_dec(saciedade_r, 2'd2);
                ene_nxt_s = sat_dec(energia_r, 2'd2);
                if (aulas_r != 8'd255) begin
                    aul_nxt_s = aulas_r + 8'd1;
                end else begin
                    aul_nxt_s = aulas_r;
                end
            end
            OP_MORTO: begin
                sac_nxt_s = saciedade_r;
                ene_nxt_s = energia_r;
            end
            default: begin
                sac_nxt_s = saciedade_r;
                ene_nxt_s = energia_r;
            end
        endcase
    end

    // Death is judged on the updated levels so it lands on the same edge they hit 0.
    assign die_s = (sac_nxt_s == 4'd0) | (ene_nxt_s == 4'd0);

    // Level registers; once dead, upd_s stays low so everything (including morreu) freezes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            saciedade_r <= 4'd15;
            energia_r   <= 4'd15;
            aulas_r     <= 8'd0;
            morreu_r    <= 1'b0;
        end else if (upd_s) begin
            saciedade_r <= sac_nxt_s;
            energia_r   <= ene_nxt_s;
            aulas_r     <= aul_nxt_s;
            morreu_r    <= die_s;
        end else begin
            saciedade_r <= saciedade_r;
            energia_r   <= energia_r;
            aulas_r     <= aulas_r;
            morreu_r    <= morreu_r;
        end
    end

    assign saciedade   = saciedade_r;
    assign energia     = energia_r;
    assign aulas       = aulas_r;
    assign morreu      = morreu_r;
    assign alerta_fome = ({28'd0, saciedade_r} <= LIM_W);
    assign alerta_sono = ({28'd0, energia_r} <= LIM_W);

endmodule

// File: tb/tb_status_vitais.sv
// Directed bench for status_vitais with TICK_DIV=4, LIMIAR=3.
module tb_status_vitais;

    logic       clk;
    logic       rst;
    logic [3:0] estado;
    logic [3:0] saciedade;
    logic [3:0] energia;
    logic [7:0] aulas;
    logic       alerta_fome;
    logic       alerta_sono;
    logic       morreu;

    int tests;
    int fails;

    status_vitais #(.TICK_DIV(4), .LIMIAR(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .estado     (estado),
        .saciedade  (saciedade),
        .energia    (energia),
        .aulas      (aulas),
        .alerta_fome(alerta_fome),
        .alerta_sono(alerta_sono),
        .morreu     (morreu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] estado;
        int         n;
        logic [3:0] sac;
        logic [3:0] ene;
        logic [7:0] aul;
        logic       fome;
        logic       sono;
        logic       mor;
    } vec_t;

    vec_t vecs[18];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] s, input logic [3:0] e,
                           input logic [7:0] a, input logic f, input logic sn, input logic m);
        chk({tag, ".saciedade"}, {4'd0, saciedade}, {4'd0, s});
        chk({tag, ".energia"}, {4'd0, energia}, {4'd0, e});
        chk({tag, ".aulas"}, aulas, a);
        chk({tag, ".alerta_fome"}, {7'd0, alerta_fome}, {7'd0, f});
        chk({tag, ".alerta_sono"}, {7'd0, alerta_sono}, {7'd0, sn});
        chk({tag, ".morreu"}, {7'd0, morreu}, {7'd0, m});
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        estado = 4'b0000;

        // IDLE run to death: first tick 4 edges after release, death at edge 60
        vecs[0]  = '{1'b1, 4'b0000, 2,  4'd15, 4'd15, 8'd0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 4'b0000, 3,  4'd15, 4'd15, 8'd0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 4'b0000, 1,  4'd14, 4'd14, 8'd0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 4'b0000, 40, 4'd4,  4'd4,  8'd0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 4'b0000, 4,  4'd3,  4'd3,  8'd0, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 4'b0000, 8,  4'd1,  4'd1,  8'd0, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 4'b0000, 4,  4'd0,  4'd0,  8'd0, 1'b1, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 4'b0001, 8,  4'd0,  4'd0,  8'd0, 1'b1, 1'b1, 1'b1};
        // DORMINDO then COMENDO: both saturate at 15
        vecs[8]  = '{1'b1, 4'b0000, 1,  4'd15, 4'd15, 8'd0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 4'b0001, 4,  4'd14, 4'd15, 8'd0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 4'b0010, 4,  4'd15, 4'd14, 8'd0, 1'b0, 1'b0, 1'b0};
        // DANDO_AULA to death, then frozen while sleeping
        vecs[11] = '{1'b1, 4'b0000, 1,  4'd15, 4'd15, 8'd0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 4'b0100, 28, 4'd1,  4'd1,  8'd7, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 4'b0100, 4,  4'd0,  4'd0,  8'd8, 1'b1, 1'b1, 1'b1};
        vecs[14] = '{1'b0, 4'b0001, 40, 4'd0,  4'd0,  8'd8, 1'b1, 1'b1, 1'b1};
        // MORTO holds levels; illegal code acts as IDLE
        vecs[15] = '{1'b1, 4'b0000, 1,  4'd15, 4'd15, 8'd0, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 4'b1000, 8,  4'd15, 4'd15, 8'd0, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 4'b0011, 4,  4'd14, 4'd14, 8'd0, 1'b0, 1'b0, 1'b0};

        @(negedge clk);
        for (int i = 0; i < 18; i++) begin
            rst    = vecs[i].rst;
            estado = vecs[i].estado;
            step(vecs[i].n);
            chk_all($sformatf("vec%0d", i), vecs[i].sac, vecs[i].ene, vecs[i].aul,
                    vecs[i].fome, vecs[i].sono, vecs[i].mor);
        end

        // Async reset mid-period while dead, then fresh tick alignment
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        estado = 4'b0000;
        step(60);
        chk_all("death60", 4'd0, 4'd0, 8'd0, 1'b1, 1'b1, 1'b1);
        step(2);
        rst = 1'b1;
        #1;
        chk_all("async_rst", 4'd15, 4'd15, 8'd0, 1'b0, 1'b0, 1'b0);
        #1;
        rst = 1'b0;
        step(3);
        chk_all("post_rst3", 4'd15, 4'd15, 8'd0, 1'b0, 1'b0, 1'b0);
        step(1);
        chk_all("post_rst4", 4'd14, 4'd14, 8'd0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/status_vitais.md
STATUS_VITAIS -- requirements
Module: status_vitais

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000, clk cycles per game tick (legal range 2..2^26).
REQ-002 SHALL have parameter LIMIAR, default 3, alert threshold, inclusive.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port estado  input  4  state code from the state controller: 0000 IDLE, 0001 DORMINDO, 0010 COMENDO, 0100 DANDO_AULA, 1000 MORTO.
REQ-006 SHALL have port saciedade  output  4  satiety level, 0..15, registered.
REQ-007 SHALL have port energia  output  4  energy level, 0..15, registered.
REQ-008 SHALL have port aulas  output  8  count of ticks spent in DANDO_AULA, registered.
REQ-009 SHALL have port alerta_fome  output  1  high while saciedade <= LIMIAR.
REQ-010 SHALL have port alerta_sono  output  1  high while energia <= LIMIAR.
REQ-011 SHALL have port morreu  output  1  death flag, registered, sticky; feeds the state controller's morreu input.

Function
REQ-012 SHALL contain a prescaler counting 0..TICK_DIV-1 that wraps to 0; internal tick is high for the one cycle in which the count equals TICK_DIV-1.
REQ-013 SHALL change saciedade, energia and aulas only on tick cycles while morreu=0.
REQ-014 SHALL apply these per-tick updates, selected by estado:
- IDLE: saciedade -1, energia -1.
- DORMINDO: saciedade -1, energia +2.
- COMENDO: saciedade +2, energia -1.
- DANDO_AULA: saciedade -2, energia -2, aulas +1.
- MORTO: no change.
REQ-015 SHALL decode any other estado code as IDLE.
REQ-016 SHALL saturate increments at 15 and decrements at 0, computing each update in 5 bits so the result never wraps.
REQ-017 SHALL saturate aulas at 255.
REQ-018 SHALL set morreu on the same edge that either saturated updated level becomes 0, including the case where both reach 0 on the same tick.
REQ-019 SHALL keep morreu=1 once set until rst, and SHALL freeze all levels and aulas while morreu=1.
REQ-020 SHALL keep the prescaler running regardless of morreu and estado.
REQ-021 SHALL drive alerta_fome and alerta_sono as a combinational decode of the level registers only, with no dependence on estado.
REQ-022 SHALL produce results with one-tick latency: an estado value sampled on a tick edge is reflected in the levels immediately after that edge.

Reset
REQ-023 SHALL, while rst=1 and independently of clk, force the following: prescaler 0, saciedade 15, energia 15, aulas 0, morreu 0.
REQ-024 SHALL, after rst deasserts, produce the first tick exactly TICK_DIV rising edges later.
REQ-025 SHALL abandon a partially counted tick period when rst is asserted mid-period, with no residual count.

Verification (TICK_DIV=4, LIMIAR=3)
REQ-026 SHALL cover: reset, hold estado=IDLE -> after 4 edges saciedade=14, energia=14; after 60 edges both are 0, morreu=1 on that edge, both alerts high from 12 ticks on.
REQ-027 SHALL cover: estado=COMENDO at saciedade=14, energia=15, one tick -> saciedade=15 (saturated), energia=14.
REQ-028 SHALL cover: estado=DANDO_AULA from reset -> after 7 ticks saciedade=energia=1, aulas=7; 8th tick -> both 0, aulas=8, morreu=1.
REQ-029 SHALL cover: morreu=1, then estado=DORMINDO for 10 ticks -> saciedade, energia and aulas unchanged, morreu stays 1.
REQ-030 SHALL cover: rst pulsed between edges with prescaler=2 and morreu=1 -> outputs reset immediately (15, 15, 0, 0); first tick 4 edges after release.
REQ-031 SHALL cover: estado=4'b0011 for one tick from reset -> saciedade=14, energia=14, aulas=0 (IDLE behaviour).
